// File: rtl/la_ctrl_pkg.sv
// Shared types for the logic-analyzer select controller: FSM states, select width
// and the scan-order helper.
package la_ctrl_pkg;

  localparam int LA_SEL_W = 4;

  typedef enum logic [1:0] {
    LA_IDLE,
    LA_BLANK,
    LA_COMMIT
  } la_state_t;

  // Next slot in scan order, wrapping from the last team back to slot 0.
  function automatic logic [LA_SEL_W-1:0] la_next_slot(input logic [LA_SEL_W-1:0] cur,
                                                       input int num_teams);
    if (int'(cur) >= num_teams) begin
      return '0;
    end
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/la_dwell_timer.sv
// Dwell counter for auto-scan: counts enabled cycles and flags the last cycle of a
// dwell period. A dwell of 0 behaves like 1. Clear or disable returns the count to 0.
module la_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] last_cnt;

  assign last_cnt = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
  assign expire_o = en_i && !clr_i && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/la_sel_ctrl.sv
// Logic-analyzer select controller: blanks la_valid around every select change so the
// consumer never samples a half-switched mux. Auto-scan is built only with LA_SEL_SCAN_EN.
module la_sel_ctrl
  import la_ctrl_pkg::*;
#(
  parameter int NUM_TEAMS    = 12,
  parameter int BLANK_CYCLES = 4,
  parameter int DWELL_W      = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                cfg_wr_en,
  input  logic [LA_SEL_W-1:0] cfg_sel,
  input  logic                cfg_scan_en,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic                err_clr,
  output logic [LA_SEL_W-1:0] la_sel,
  output logic                la_valid,
  output logic                busy,
  output logic                sel_err
);

  localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_CYCLES - 1);

  la_state_t           state_q, state_d;
  logic [BCW-1:0]      blank_cnt_q, blank_cnt_d;
  logic [LA_SEL_W-1:0] sel_q, sel_d;
  logic [LA_SEL_W-1:0] tgt_q, tgt_d;
  logic [LA_SEL_W-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                err_q, err_d;

  logic                wr_ok;
  logic                wr_bad;
  logic                req_v;
  logic [LA_SEL_W-1:0] req_sel;
  logic                scan_step;

  assign wr_bad  = cfg_wr_en && (int'(cfg_sel) > NUM_TEAMS);
  assign wr_ok   = cfg_wr_en && !wr_bad;
  // A fresh write is newer than anything parked in pending, so it takes precedence.
  assign req_v   = wr_ok || pend_v_q;
  assign req_sel = wr_ok ? cfg_sel : pend_q;

`ifdef LA_SEL_SCAN_EN
  la_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .nrst     (nrst),
    .en_i     ((state_q == LA_IDLE) && cfg_scan_en),
    .clr_i    (req_v),
    .dwell_i  (cfg_dwell),
    .expire_o (scan_step)
  );
`else
  logic unused_scan_cfg;
  assign unused_scan_cfg = cfg_scan_en ^ (^cfg_dwell);
  assign scan_step       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    sel_d       = sel_q;
    tgt_d       = tgt_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    err_d       = err_q;

    if (wr_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      LA_IDLE: begin
        blank_cnt_d = '0;
        if (req_v) begin
          pend_v_d = 1'b0;
          if (req_sel != sel_q) begin
            tgt_d   = req_sel;
            state_d = LA_BLANK;
          end
        end else if (scan_step) begin
          tgt_d   = la_next_slot(sel_q, NUM_TEAMS);
          state_d = LA_BLANK;
        end
      end
      LA_BLANK: begin
        if (wr_ok) begin
          pend_d   = cfg_sel;
          pend_v_d = 1'b1;
        end
        // The select is loaded on the way into COMMIT so it is already stable
        // during the COMMIT cycle, one cycle before la_valid returns.
        if (blank_cnt_q == BLANK_LAST) begin
          sel_d   = tgt_q;
          state_d = LA_COMMIT;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      LA_COMMIT: begin
        if (wr_ok) begin
          pend_d   = cfg_sel;
          pend_v_d = 1'b1;
        end
        state_d = LA_IDLE;
      end
      default: begin
        state_d = LA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= LA_IDLE;
      blank_cnt_q <= '0;
      sel_q       <= '0;
      tgt_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      err_q       <= err_d;
    end
  end

  assign la_sel   = sel_q;
  assign la_valid = (state_q == LA_IDLE);
  assign busy     = !la_valid;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_la_sel_ctrl.sv
// Scoreboard bench for la_sel_ctrl: a transaction-level model predicts each select
// change and its timing; a negedge monitor checks what the DUT presents.
module tb_la_sel_ctrl;

  localparam int NT = 12;
  localparam int BC = 4;
  localparam int DW = 16;

  logic          clk;
  logic          nrst;
  logic          cfg_wr_en;
  logic [3:0]    cfg_sel;
  logic          cfg_scan_en;
  logic [DW-1:0] cfg_dwell;
  logic          err_clr;
  logic [3:0]    la_sel;
  logic          la_valid;
  logic          busy;
  logic          sel_err;

  la_sel_ctrl #(
    .NUM_TEAMS    (NT),
    .BLANK_CYCLES (BC),
    .DWELL_W      (DW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_sel     (cfg_sel),
    .cfg_scan_en (cfg_scan_en),
    .cfg_dwell   (cfg_dwell),
    .err_clr     (err_clr),
    .la_sel      (la_sel),
    .la_valid    (la_valid),
    .busy        (busy),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Expected select changes: target value and the edge at which it was accepted.
  typedef struct {
    int tgt;
    int k0;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int m_sel, m_idle_at, m_pend, m_pend_v, m_err, m_cnt;

  function automatic void model_reset();
    m_sel     = 0;
    m_idle_at = 0;
    m_pend    = 0;
    m_pend_v  = 0;
    m_err     = 0;
    m_cnt     = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input int t);
    exp_q.push_back('{tgt: t, k0: cyc});
    m_sel     = t;
    m_idle_at = cyc + BC + 2;
  endfunction

  // Reference model: accepted request -> BC blank cycles + 1 commit cycle, then idle.
  always @(posedge clk) begin
    int  t;
    int  eff;
    bit  idle, ok, bad;
    cyc++;
    if (!nrst) begin
      model_reset();
    end else begin
      idle = (cyc >= m_idle_at);
      bad  = cfg_wr_en && (int'(cfg_sel) > NT);
      ok   = cfg_wr_en && !bad;
      if (bad) m_err = 1;
      else if (err_clr) m_err = 0;
      eff = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
      if (idle) begin
        if (ok || m_pend_v) begin
          t        = ok ? int'(cfg_sel) : m_pend;
          m_pend_v = 0;
          m_cnt    = 0;
          if (t != m_sel) model_accept(t);
        end else begin
`ifdef LA_SEL_SCAN_EN
          if (cfg_scan_en) begin
            m_cnt++;
            if (m_cnt == eff) begin
              m_cnt = 0;
              model_accept((m_sel == NT) ? 0 : m_sel + 1);
            end
          end else begin
            m_cnt = 0;
          end
`else
          m_cnt = 0;
`endif
        end
      end else begin
        m_cnt = 0;
        if (ok) begin
          m_pend   = int'(cfg_sel);
          m_pend_v = 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard when the DUT completes a select change.
  int prev_sel   = 0;
  bit prev_valid = 1'b1;
  always @(negedge clk) begin
    if (!nrst) begin
      prev_sel   = 0;
      prev_valid = 1'b1;
    end else begin
      check("busy_vs_valid", int'(busy), int'(!la_valid));
      check("sel_err", int'(sel_err), m_err);
      if (prev_valid && !la_valid) begin
        check("blank_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) check("blank_start_cycle", cyc, exp_q[0].k0);
      end
      if (int'(la_sel) != prev_sel) begin
        check("sel_change_expected", exp_q.size(), 1);
        check("valid_low_at_sel_change", int'(la_valid), 0);
        if (exp_q.size() > 0) begin
          check("sel_change_value", int'(la_sel), exp_q[0].tgt);
          check("sel_change_cycle", cyc, exp_q[0].k0 + BC);
        end
      end
      if (!prev_valid && la_valid) begin
        check("valid_rise_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          check("valid_rise_cycle", cyc, exp_q[0].k0 + BC + 1);
          check("committed_sel", int'(la_sel), exp_q[0].tgt);
          $display("commit sel=%0d accepted_edge=%0d valid_edge=%0d", la_sel, exp_q[0].k0, cyc);
          void'(exp_q.pop_front());
        end
      end
      prev_sel   = int'(la_sel);
      prev_valid = la_valid;
    end
  end

  task automatic drive(input bit wr, input logic [3:0] sel, input bit clr);
    @(negedge clk);
    cfg_wr_en = wr;
    cfg_sel   = sel;
    err_clr   = clr;
    if (wr) $display("write sel=%0d clr=%0d edge=%0d", sel, clr, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0);
  endtask

  // Asynchronous reset between clock edges; outputs must return to reset values at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    cfg_wr_en = 1'b0;
    err_clr   = 1'b0;
    nrst      = 1'b0;
    model_reset();
    #1;
    check("rst_la_sel", int'(la_sel), 0);
    check("rst_la_valid", int'(la_valid), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_sel_err", int'(sel_err), 0);
    $display("reset applied at %0t", $time);
    @(posedge clk);
    #2;
    nrst = 1'b1;
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst        = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_sel     = '0;
    cfg_scan_en = 1'b0;
    cfg_dwell   = DW'(10);
    err_clr     = 1'b0;
    model_reset();
    do_reset();
    idle(3);

    // Single write, latency via monitor.
    drive(1'b1, 4'd7, 1'b0);
    idle(10);
    check("t2_sel", int'(la_sel), 7);

    // Writes during blank: latest wins, 5 never appears.
    drive(1'b1, 4'd3, 1'b0);
    drive(1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd9, 1'b0);
    idle(16);
    check("t3_sel", int'(la_sel), 9);

    // Same-value write is a no-op (monitor flags any blank).
    drive(1'b1, 4'd9, 1'b0);
    idle(4);

    // Invalid writes and sticky error.
    drive(1'b1, 4'd13, 1'b0);
    idle(2);
    check("t4_sel_unchanged", int'(la_sel), 9);
    check("t4_valid", int'(la_valid), 1);
    check("t4_err_set", int'(sel_err), 1);
    drive(1'b0, 4'd0, 1'b1);
    idle(1);
    check("t4_err_cleared", int'(sel_err), 0);
    drive(1'b1, 4'd15, 1'b1);
    idle(1);
    check("t4_err_wins_over_clr", int'(sel_err), 1);
    drive(1'b0, 4'd0, 1'b1);
    idle(2);

    // Reset during blank of write 6.
    drive(1'b1, 4'd6, 1'b0);
    idle(2);
    do_reset();
    idle(10);
    check("t6_sel_after_reset", int'(la_sel), 0);

`ifdef LA_SEL_SCAN_EN
    drive(1'b1, 4'd12, 1'b0);
    idle(8);
    cfg_dwell   = DW'(10);
    cfg_scan_en = 1'b1;
    idle(40);
    cfg_scan_en = 1'b0;
    idle(10);
`endif

    // Randomized traffic, including scan toggling (ignored in the default build).
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) cfg_scan_en = 1'b0;
      if (i % 200 == 5) begin
        cfg_dwell   = DW'($urandom_range(0, 6));
        cfg_scan_en = 1'($urandom_range(0, 1));
      end
      if (i == 700) begin
        do_reset();
      end else begin
        drive(($urandom % 5) == 0, 4'($urandom % 16), ($urandom % 16) == 0);
      end
    end

    cfg_scan_en = 1'b0;
    idle(20);
    check("end_valid", int'(la_valid), 1);
    check("end_queue_empty", exp_q.size(), 0);
    finish_run();
  end

endmodule
